ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

FIFO controller that turns the single-port 16x8 synchronous RAM (`sync_ram`) into a valid/ready stream buffer. It sits directly upstream of the RAM: it owns the RAM's `we`/`addr`/`din` and consumes its registered `dout`. It presents a push interface to the producer and a pop interface to the consumer. One RAM access per cycle; writes have priority over reads.

## Interface
- `DATA_W`, 8: word width; equals the RAM data width.
- `ADDR_W`, 4: RAM address width; RAM depth is `DEPTH = 2**ADDR_W` = 16.
- `clk`  in  1  rising-edge clock shared with the RAM.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  DATA_W  producer word.
- `in_ready`  out  1  registered; controller accepts the word this cycle.
- `out_valid`  out  1  registered; `out_data` holds the oldest word.
- `out_data`  out  DATA_W  registered head-of-FIFO word.
- `out_ready`  in  1  consumer takes `out_data` this cycle.
- `level`  out  ADDR_W+1  registered; total words held = `mem_cnt + rd_pend + out_valid`.
- `full`  out  1  registered; `mem_cnt == DEPTH`.
- `empty`  out  1  registered; `level == 0`.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_din`  out  DATA_W  to RAM `din`.
- `ram_dout`  in  DATA_W  from RAM `dout`; valid one cycle after the read address is sampled.

## Operation
- State: `wr_ptr`, `rd_ptr` (ADDR_W bits, wrap DEPTH-1 -> 0 by natural overflow); `mem_cnt` (0..DEPTH); `rd_pend` flag; output register (`out_valid`/`out_data`).
- Push: `wr_go = in_valid & in_ready`. Drives `ram_we=1`, `ram_addr=wr_ptr`, `ram_din=in_data`. At the edge: `wr_ptr++`, `mem_cnt++`.
- Read issue: `rd_go = !wr_go & (mem_cnt != 0) & !rd_pend & (!out_valid | out_ready)`. Drives `ram_we=0`, `ram_addr=rd_ptr`. At the edge: `rd_ptr++`, `mem_cnt--`, `rd_pend<=1`.
- Capture: when `rd_pend` is 1, `out_data <= ram_dout`, `out_valid <= 1`, `rd_pend <= 0`. The issue condition guarantees the output register is free at capture.
- Pop: `out_valid & out_ready` with no capture this cycle clears `out_valid`. `out_data` holds its value.
- Idle (no `wr_go`, no `rd_go`): `ram_we=0`, `ram_addr=rd_ptr`, `ram_din=in_data`. All `ram_*` outputs are combinational from registered state plus `in_valid`.
- `in_ready <= (mem_cnt_next != DEPTH)`. It has no combinational path from `in_valid` or `out_ready`.
- Capacity: DEPTH words in the RAM plus one in the output register, so `level` max is DEPTH+1 = 17.
- Write priority: continuous pushes stall prefetch. Reads resume on the first cycle without `wr_go`. When full, `in_ready=0`, so reads always progress.
- Push while `in_ready=0`: the word is ignored and no state changes.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_data=0`, `level=0`, `full=0`, `empty=1`, pointers 0, `mem_cnt=0`, `rd_pend=0`, `ram_we=0`, `ram_addr=0`.
- First rising edge after `rst_n` deasserts: `in_ready` goes 1.
- Write accepted at edge E; the RAM stores the word at the same edge E.
- Empty-to-output latency: push at edge E, read issue at E+1 (if no push in that cycle), `out_valid` high after E+2.
- Sustained drain rate: one word per 2 cycles (issue, capture).
- Simultaneous push and pop with the output register valid:
  - The push wins the RAM.
  - The pop clears `out_valid`.
  - The refill read issues on the next free cycle.
- `rst_n` asserted mid-operation: all state clears immediately and contents are lost. A read in flight is discarded.

## Configuration
- `RAM_FIFO_FLUSH_EN` defined: adds input port `flush` (1 bit, synchronous, active-high).
  - When `flush` is sampled high, all state returns to reset values, except `in_ready`, which is 1 on the next cycle.
  - A push in the same cycle is dropped: `ram_we` is forced 0.
  - `flush` overrides capture and pop.
- `RAM_FIFO_FLUSH_EN` undefined: no `flush` port and no flush logic.

## Test plan
- Reset, then push A5, 3C, 7E on consecutive cycles with `out_ready=1` -> pops in order A5, 3C, 7E. First `out_valid` appears 2 cycles after the last push (writes stall prefetch). `level` returns to 0 and `empty=1`.
- Push 17 words (00..10) with `out_ready=0` -> after 16 pushes `full=1` and `in_ready=0`. Prefetch lifts word 00 into `out_data`, `full` drops, and the 17th push is accepted: `level=17`, `full=1`. Pop all 17 -> values 00..10 in order.
- Wrap-around: 3 rounds of push-16/pop-16 -> no loss or reordering. `wr_ptr` and `rd_ptr` end at 0.
- Continuous `in_valid=1` while the consumer is ready -> prefetch stalls until `full`. Then reads drain at 1 word per 2 cycles while pushes refill as `in_ready` reasserts.
- Assert `rst_n=0` with 5 words held and a read in flight -> all outputs read their reset values asynchronously. After release, pushing 42 pops 42.
- With `RAM_FIFO_FLUSH_EN`: hold 4 words, assert `flush` together with a push of 99 -> `level=0` and `empty=1` next cycle, and 99 is never popped.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready stream bundle for ram_fifo_ctrl: producer push side and consumer pop side.
// The controller connects to the slave modport and the environment to the master modport.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a single-port synchronous RAM as a valid/ready buffer with a
// one-word output register. Optional synchronous flush port enabled by RAM_FIFO_FLUSH_EN.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef RAM_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    ram_fifo_ctrl_if.slave    stream,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    typedef struct packed {
        ptr_t              wr_ptr;
        ptr_t              rd_ptr;
        cnt_t              mem_cnt;
        logic              rd_pend;
        logic              out_valid;
        logic [DATA_W-1:0] out_data;
        logic              in_ready;
        cnt_t              level;
        logic              full;
        logic              empty;
    } state_t;

    localparam state_t RESET_STATE = '{
        wr_ptr:    '0,
        rd_ptr:    '0,
        mem_cnt:   '0,
        rd_pend:   1'b0,
        out_valid: 1'b0,
        out_data:  '0,
        in_ready:  1'b0,
        level:     '0,
        full:      1'b0,
        empty:     1'b1
    };

    state_t st_q, st_d;
    logic   wr_go, rd_go, flush_c;

`ifdef RAM_FIFO_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // NOTE: every signal written here gets a value before any branch so no latch is inferred.
    always_comb begin
        st_d  = st_q;
        wr_go = stream.in_valid & st_q.in_ready & ~flush_c;
        // Writes own the RAM port; a read issues only when the output register will be free.
        rd_go = ~wr_go & (st_q.mem_cnt != '0) & ~st_q.rd_pend
              & (~st_q.out_valid | stream.out_ready) & ~flush_c;

        ram_we   = wr_go;
        ram_addr = wr_go ? st_q.wr_ptr : st_q.rd_ptr;
        ram_din  = stream.in_data;

        if (wr_go) st_d.wr_ptr = st_q.wr_ptr + ptr_t'(1);
        if (rd_go) st_d.rd_ptr = st_q.rd_ptr + ptr_t'(1);
        st_d.mem_cnt = st_q.mem_cnt + cnt_t'(wr_go) - cnt_t'(rd_go);
        st_d.rd_pend = rd_go;

        // RAM data is registered, so the word read last cycle lands in the output register now.
        if (st_q.rd_pend) begin
            st_d.out_valid = 1'b1;
            st_d.out_data  = ram_dout;
        end else if (st_q.out_valid && stream.out_ready) begin
            st_d.out_valid = 1'b0;
        end

        st_d.in_ready = (st_d.mem_cnt != DEPTH_CNT);
        st_d.full     = (st_d.mem_cnt == DEPTH_CNT);
        st_d.level    = st_d.mem_cnt + cnt_t'(st_d.rd_pend) + cnt_t'(st_d.out_valid);
        st_d.empty    = (st_d.level == '0);

        if (flush_c) begin
            st_d          = RESET_STATE;
            st_d.in_ready = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= RESET_STATE;
        else        st_q <= st_d;
    end

    assign stream.in_ready  = st_q.in_ready;
    assign stream.out_valid = st_q.out_valid;
    assign stream.out_data  = st_q.out_data;
    assign level            = st_q.level;
    assign full             = st_q.full;
    assign empty            = st_q.empty;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM, queue-based reference model,
// scoreboard monitor on the falling edge, directed scenarios plus randomized traffic.
module tb_ram_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush = 1'b0;
    logic [ADDR_W:0]   level;
    logic              full, empty, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    ram_fifo_ctrl_if #(.DATA_W(DATA_W)) stream ();

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef RAM_FIFO_FLUSH_EN
        .flush    (flush),
`endif
        .stream   (stream.slave),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered read data.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int                n_checks  = 0;
    int                n_pass    = 0;
    int                pop_count = 0;
    bit                mon_en    = 1'b0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: level mirrors words held; pops must return the oldest accepted word.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("level", 32'(level), 32'(exp_q.size()));
            check("empty", 32'(empty), 32'(exp_q.size() == 0));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (stream.out_valid && stream.out_ready) begin
                    pop_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL pop: got %0h, expected no word", stream.out_data);
                    end else begin
                        check("out_data", 32'(stream.out_data), 32'(exp_q.pop_front()));
                    end
                end
                if (stream.in_valid && stream.in_ready) exp_q.push_back(stream.in_data);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        flush            = 1'b0;
        stream.in_valid  = 1'b0;
        stream.out_ready = 1'b0;
        exp_q.delete();
        #1;
        check("rst_in_ready",  32'(stream.in_ready),  0);
        check("rst_out_valid", 32'(stream.out_valid), 0);
        check("rst_out_data",  32'(stream.out_data),  0);
        check("rst_level",     32'(level),            0);
        check("rst_full",      32'(full),             0);
        check("rst_empty",     32'(empty),            1);
        check("rst_ram_we",    32'(ram_we),           0);
        check("rst_ram_addr",  32'(ram_addr),         0);
        #10;
        rst_n = 1'b1;
        check("rst_release_in_ready", 32'(stream.in_ready), 0);
        step();
        check("first_edge_in_ready", 32'(stream.in_ready), 1);
    endtask

    task automatic push_burst(input int n, input logic [DATA_W-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            stream.in_valid = 1'b1;
            stream.in_data  = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
            step();
        end
        stream.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        stream.out_ready = 1'b1;
        while ((exp_q.size() != 0 || stream.out_valid) && n < 300) begin
            step();
            n++;
        end
        check({name, "_drain_done"}, 32'(n < 300), 1);
        check({name, "_drain_level"}, 32'(level), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  saw_full;
        int  pops_start;
        stream.in_valid  = 1'b0;
        stream.in_data   = '0;
        stream.out_ready = 1'b0;
        step();
        do_reset();
        mon_en = 1'b1;

        // Three back-to-back pushes; reads stall until the pushes stop.
        stream.out_ready = 1'b1;
        push_burst(1, 8'hA5, 1'b0);
        push_burst(1, 8'h3C, 1'b0);
        push_burst(1, 8'h7E, 1'b0);
        step();
        check("t1_no_early_valid", 32'(stream.out_valid), 0);
        step();
        check("t1_latency_valid", 32'(stream.out_valid), 1);
        check("t1_first_word", 32'(stream.out_data), 32'h A5);
        drain("t1");
        check("t1_empty", 32'(empty), 1);

        // Fill the RAM, let prefetch free a slot, then the 17th word fits.
        stream.out_ready = 1'b0;
        push_burst(16, 8'h00, 1'b0);
        check("t2_full", 32'(full), 1);
        check("t2_in_ready_low", 32'(stream.in_ready), 0);
        check("t2_level16", 32'(level), 16);
        stream.in_valid = 1'b1;
        stream.in_data  = 8'h10;
        n = 0;
        while (!stream.in_ready && n < 20) begin
            step();
            n++;
        end
        check("t2_ready_returns", 32'(stream.in_ready), 1);
        step();
        stream.in_valid = 1'b0;
        check("t2_level17", 32'(level), 17);
        check("t2_full17", 32'(full), 1);
        check("t2_head", 32'(stream.out_data), 0);
        drain("t2");

        // Wrap-around: pointers return to zero after 48 words.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            stream.out_ready = 1'b0;
            push_burst(16, 8'h00, 1'b1);
            check("t3_full", 32'(full), 1);
            drain("t3");
        end
        check("t3_rd_ptr_zero", 32'(ram_addr), 0);
        stream.in_valid = 1'b1;
        stream.in_data  = DATA_W'($urandom);
        #1;
        check("t3_wr_we", 32'(ram_we), 1);
        check("t3_wr_ptr_zero", 32'(ram_addr), 0);
        step();
        stream.in_valid = 1'b0;
        drain("t3b");

        // Continuous pushes with a ready consumer: fill, then one word per two cycles.
        stream.out_ready = 1'b1;
        saw_full   = 1'b0;
        pops_start = 0;
        for (int i = 0; i < 100; i++) begin
            stream.in_valid = 1'b1;
            stream.in_data  = DATA_W'($urandom);
            step();
            if (full && !saw_full) begin
                saw_full   = 1'b1;
                pops_start = -1;
            end
            if (pops_start == -1 && i >= 40) pops_start = pop_count;
        end
        check("t4_reached_full", 32'(saw_full), 1);
        stream.in_valid = 1'b0;
        check("t4_rate", 32'((pop_count - pops_start) >= 28 && (pop_count - pops_start) <= 32), 1);
        drain("t4");

        // Reset with five words held and a read in flight.
        do_reset();
        push_burst(5, 8'h00, 1'b1);
        step();
        check("t5_level5", 32'(level), 5);
        do_reset();
        push_burst(1, 8'h42, 1'b0);
        stream.out_ready = 1'b1;
        step(2);
        check("t5_valid", 32'(stream.out_valid), 1);
        check("t5_word", 32'(stream.out_data), 32'h42);
        drain("t5");

`ifdef RAM_FIFO_FLUSH_EN
        // Flush with a simultaneous push: the pushed word is dropped.
        stream.out_ready = 1'b0;
        push_burst(4, 8'h00, 1'b1);
        step(3);
        check("t6_level4", 32'(level), 4);
        flush           = 1'b1;
        stream.in_valid = 1'b1;
        stream.in_data  = 8'h99;
        #1;
        check("t6_we_blocked", 32'(ram_we), 0);
        step();
        flush           = 1'b0;
        stream.in_valid = 1'b0;
        check("t6_level0", 32'(level), 0);
        check("t6_empty", 32'(empty), 1);
        check("t6_in_ready", 32'(stream.in_ready), 1);
        check("t6_out_valid", 32'(stream.out_valid), 0);
        push_burst(3, 8'h01, 1'b0);
        drain("t6");
`endif

        // Randomized traffic at several push/pop densities.
        for (int seg = 0; seg < 4; seg++) begin
            int p_in;
            int p_out;
            p_in  = (seg == 0) ? 80 : (seg == 1) ? 30 : (seg == 2) ? 60 : 95;
            p_out = (seg == 0) ? 30 : (seg == 1) ? 80 : (seg == 2) ? 60 : 50;
            for (int i = 0; i < 400; i++) begin
                stream.in_valid  = ($urandom_range(99) < p_in);
                stream.in_data   = DATA_W'($urandom);
                stream.out_ready = ($urandom_range(99) < p_out);
                step();
            end
        end
        stream.in_valid = 1'b0;
        drain("rand");

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
